// File: rtl/fir_pkg.sv
// Shared widths, FSM encoding and output rounding for the stereo FIR MAC scheduler.
package fir_pkg;
    localparam int TAPS       = 45;
    localparam int DATA_W     = 24;
    localparam int COEF_W     = 16;
    localparam int ACC_W      = 46;
    localparam int FILT_SEL_W = 3;
    localparam int Q_SHIFT    = 15;
    localparam int TAP_W      = 6;
    localparam int ADDR_W     = FILT_SEL_W + TAP_W;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic [TAP_W-1:0]         tap_t;

    typedef logic [2:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE  = 3'd0;
    localparam fsm_state_t ST_LOAD  = 3'd1;
    localparam fsm_state_t ST_MAC   = 3'd2;
    localparam fsm_state_t ST_DRAIN = 3'd3;
    localparam fsm_state_t ST_ROUND = 3'd4;

    localparam acc_t SAT_MAX = acc_t'((2 ** (DATA_W - 1)) - 1);
    localparam acc_t SAT_MIN = -acc_t'(2 ** (DATA_W - 1));

    // Q1.15 product sum back to a sample: round half up, then clamp to the sample range.
    function automatic sample_t round_sat(input acc_t acc);
        acc_t rounded;
        rounded = (acc + (acc_t'(1) <<< (Q_SHIFT - 1))) >>> Q_SHIFT;
        if (rounded > SAT_MAX) begin
            rounded = SAT_MAX;
        end else if (rounded < SAT_MIN) begin
            rounded = SAT_MIN;
        end
        return rounded[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/fir_history_ram.sv
// One channel of circular sample history: single write port, combinational read, cleared by rst.
module fir_history_ram
    import fir_pkg::*;
#(
    parameter int DEPTH = TAPS,
    parameter int AW    = TAP_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  sample_t       wdata,
    input  logic [AW-1:0] raddr,
    output sample_t       rdata
);
    sample_t mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/fir_mac_scheduler.sv
// Stereo 45-tap FIR sequencer: one shared MAC walks both channels per packet and
// returns the rounded, saturated pair (or the raw pair in bypass).
module fir_mac_scheduler
    import fir_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 sw,
    input  logic                       new_packet,
    input  logic [1:0][DATA_W-1:0]     input_data,
    output logic [ADDR_W-1:0]          coef_addr,
    input  logic [COEF_W-1:0]          coef_data,
    output logic [1:0][DATA_W-1:0]     output_data,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       overrun,
    output logic [FILT_SEL_W-1:0]      selected_filter
);
    fsm_state_t              state_q, state_d;
    tap_t                    tap_q, tap_d;
    logic                    ch_q, ch_d;
    tap_t                    ptr_q;
    tap_t                    rd_idx;
    logic [1:0][DATA_W-1:0]  in_q;
    logic [FILT_SEL_W-1:0]   sel_q;
    logic                    bypass_q;
    sample_t                 sample_q;
    logic                    prod_vld_q, prod_clr_q, prod_ch_q;
    acc_t                    acc_q, acc0_q, prod;
    logic [1:0][DATA_W-1:0]  out_q;
    logic                    out_valid_q, busy_q, overrun_q;
    sample_t                 hist_rd [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hist
            fir_history_ram u_hist (
                .clk   (clk),
                .rst   (rst),
                .we    (state_q == ST_LOAD),
                .waddr (ptr_q),
                .wdata (in_q[gi]),
                .raddr (rd_idx),
                .rdata (hist_rd[gi])
            );
        end
    endgenerate

    // Tap k looks k samples back from the newest entry, wrapping 0 -> TAPS-1.
    assign rd_idx = (ptr_q >= tap_q) ? (ptr_q - tap_q) : (ptr_q + tap_t'(TAPS) - tap_q);
    assign prod   = acc_t'(sample_q) * acc_t'(coef_t'(coef_data));

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        ch_d    = ch_q;
        case (state_q)
            ST_IDLE: begin
                if (new_packet) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_MAC;
                tap_d   = '0;
                ch_d    = 1'b0;
            end
            ST_MAC: begin
                if (tap_q == tap_t'(TAPS - 1)) begin
                    tap_d = '0;
                    ch_d  = 1'b1;
                    if (ch_q) begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            ST_DRAIN: state_d = ST_ROUND;
            ST_ROUND: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tap_q       <= '0;
            ch_q        <= 1'b0;
            ptr_q       <= '0;
            in_q        <= '0;
            sel_q       <= '0;
            bypass_q    <= 1'b0;
            sample_q    <= '0;
            prod_vld_q  <= 1'b0;
            prod_clr_q  <= 1'b0;
            prod_ch_q   <= 1'b0;
            acc_q       <= '0;
            acc0_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            ch_q        <= ch_d;
            out_valid_q <= 1'b0;

            if (new_packet && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
            if (new_packet && (state_q == ST_IDLE)) begin
                in_q     <= input_data;
                sel_q    <= sw[2:0];
                bypass_q <= sw[3];
                busy_q   <= 1'b1;
            end

            // Sample is staged one cycle so it meets the ROM word for the same issue.
            prod_vld_q <= (state_q == ST_MAC);
            prod_clr_q <= (tap_q == '0);
            prod_ch_q  <= ch_q;
            sample_q   <= hist_rd[ch_q];

            if (prod_vld_q) begin
                if (prod_clr_q) begin
                    acc_q <= prod;
                    if (prod_ch_q) begin
                        acc0_q <= acc_q;
                    end
                end else begin
                    acc_q <= acc_q + prod;
                end
            end

            if (state_q == ST_ROUND) begin
                out_q[0]    <= bypass_q ? in_q[0] : round_sat(acc0_q);
                out_q[1]    <= bypass_q ? in_q[1] : round_sat(acc_q);
                out_valid_q <= 1'b1;
                busy_q      <= 1'b0;
                ptr_q       <= (ptr_q == tap_t'(TAPS - 1)) ? '0 : ptr_q + 1'b1;
            end
        end
    end

    assign coef_addr       = {sel_q, tap_q};
    assign output_data     = out_q;
    assign out_valid       = out_valid_q;
    assign busy            = busy_q;
    assign overrun         = overrun_q;
    assign selected_filter = sel_q;
endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed + randomized bench for fir_mac_scheduler against a direct-form FIR model
// computed over the list of accepted packets.
module tb_fir_mac_scheduler;
    import fir_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [3:0]            sw;
    logic                  new_packet;
    logic [1:0][23:0]      input_data;
    logic [8:0]            coef_addr;
    logic [15:0]           coef_data;
    logic [1:0][23:0]      output_data;
    logic                  out_valid;
    logic                  busy;
    logic                  overrun;
    logic [2:0]            selected_filter;

    logic [15:0] rom [0:511];
    longint      hist_l[$];
    longint      hist_r[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    fir_mac_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .sw              (sw),
        .new_packet      (new_packet),
        .input_data      (input_data),
        .coef_addr       (coef_addr),
        .coef_data       (coef_data),
        .output_data     (output_data),
        .out_valid       (out_valid),
        .busy            (busy),
        .overrun         (overrun),
        .selected_filter (selected_filter)
    );

    always #5 clk = ~clk;

    // External coefficient ROM with one cycle of read latency.
    always @(posedge clk) coef_data <= rom[coef_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // y = sum_k coef[sel][k] * x[n-k], rounded half up from Q1.15 and clamped to 24 bits.
    function automatic logic [23:0] model_y(input int ch, input int sel);
        longint acc;
        longint y;
        longint s;
        int     n;
        logic [63:0] y_bits;
        acc = 0;
        n = (ch == 0) ? hist_l.size() : hist_r.size();
        for (int k = 0; k < TAPS; k++) begin
            if (n - 1 - k >= 0) begin
                s = (ch == 0) ? hist_l[n-1-k] : hist_r[n-1-k];
                acc += longint'($signed(rom[sel*64 + k])) * s;
            end
        end
        y = (acc + 16384) >>> 15;
        if (y > 8388607)  y = 8388607;
        if (y < -8388608) y = -8388608;
        y_bits = y;
        return y_bits[23:0];
    endfunction

    task automatic do_packet(input logic [23:0] l, input logic [23:0] r, input logic [3:0] swv,
                             input int glitch_at, input int sw_change_at, input logic [3:0] sw_new);
        int          cycles;
        int          busy_cnt;
        int          sel;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
        @(negedge clk);
        new_packet    = 1'b1;
        input_data[0] = l;
        input_data[1] = r;
        sw            = swv;
        hist_l.push_back(longint'($signed(l)));
        hist_r.push_back(longint'($signed(r)));
        sel   = int'(swv[2:0]);
        exp_l = swv[3] ? l : model_y(0, sel);
        exp_r = swv[3] ? r : model_y(1, sel);
        @(negedge clk);
        new_packet    = 1'b0;
        input_data[0] = 24'($urandom);
        input_data[1] = 24'($urandom);
        cycles   = 0;
        busy_cnt = 0;
        while (out_valid !== 1'b1 && cycles < 200) begin
            if (busy === 1'b1) busy_cnt++;
            if (cycles == sw_change_at) sw = sw_new;
            if (sw_change_at >= 0 && cycles == sw_change_at + 9) begin
                check("sel_hold", 64'(selected_filter), 64'(swv[2:0]));
                check("addr_hold", 64'(coef_addr[8:6]), 64'(swv[2:0]));
            end
            new_packet = (cycles == glitch_at);
            @(negedge clk);
            cycles++;
        end
        new_packet = 1'b0;
        check("latency", 64'(cycles), 64'd93);
        check("busy_cycles", 64'(busy_cnt), 64'd93);
        check("out_L", 64'(output_data[0]), 64'(exp_l));
        check("out_R", 64'(output_data[1]), 64'(exp_r));
        check("sel", 64'(selected_filter), 64'(swv[2:0]));
        $display("packet L=%06h R=%06h sw=%h -> L=%06h R=%06h after %0d cycles",
                 l, r, swv, output_data[0], output_data[1], cycles);
        @(negedge clk);
        check("valid_pulse", 64'(out_valid), 64'd0);
        check("held_L", 64'(output_data[0]), 64'(exp_l));
    endtask

    initial begin
        logic [23:0] a;
        logic [23:0] b;
        logic [2:0]  s;
        int          nvalid;

        rst = 1'b1;
        sw = 4'd0;
        new_packet = 1'b0;
        input_data = '0;
        for (int i = 0; i < 512; i++) rom[i] = 16'h0000;
        rom[0] = 16'h4000;
        for (int k = 0; k < TAPS; k++) begin
            rom[64 + k]  = 16'(k + 1);
            rom[128 + k] = 16'($urandom);
            rom[192 + k] = 16'h7FFF;
            for (int f = 4; f < 8; f++) rom[f*64 + k] = 16'($urandom);
        end

        repeat (3) @(negedge clk);
        check("rst_out", 64'(output_data), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_sel", 64'(selected_filter), 64'd0);
        check("rst_addr", 64'(coef_addr), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unit impulse through filter 0.
        do_packet(24'h100000, 24'hF0000F, 4'd0, -1, -1, 4'd0);
        check("imp_L", 64'(output_data[0]), 64'h080000);
        check("imp_R", 64'(output_data[1]), 64'hF80008);

        // Impulse walks through all 45 taps of filter 1, then falls off the end.
        do_packet(24'h100000, 24'h000000, 4'd1, -1, -1, 4'd0);
        for (int j = 1; j <= 45; j++) begin
            do_packet(24'h0, 24'h0, 4'd1, -1, -1, 4'd0);
            if (j == 44) check("wrap_last_tap", 64'(output_data[0]), 64'h0005A0);
        end
        check("wrap_out_L", 64'(output_data[0]), 64'd0);
        check("wrap_out_R", 64'(output_data[1]), 64'd0);

        // Switches change mid-MAC: the packet stays on filter 1.
        do_packet(24'($urandom), 24'($urandom), 4'd1, -1, 11, 4'd2);

        // Bypass returns the raw input exactly.
        a = 24'($urandom);
        b = 24'($urandom);
        do_packet(a, b, 4'b1101, -1, -1, 4'd0);
        check("bypass_L", 64'(output_data[0]), 64'(a));
        check("bypass_R", 64'(output_data[1]), 64'(b));

        for (int i = 0; i < 8; i++) begin
            s = 3'($urandom_range(0, 7));
            do_packet(24'($urandom), 24'($urandom), {1'b0, s}, -1, -1, 4'd0);
        end

        // Overrun: dropped packet must not enter history.
        check("overrun_clear", 64'(overrun), 64'd0);
        do_packet(24'($urandom), 24'($urandom), 4'd5, 20, -1, 4'd0);
        check("overrun_set", 64'(overrun), 64'd1);
        do_packet(24'($urandom), 24'($urandom), 4'd6, -1, -1, 4'd0);
        check("overrun_sticky", 64'(overrun), 64'd1);

        // Saturation both ways.
        repeat (45) do_packet(24'h7FFFFF, 24'h7FFFFF, 4'd3, -1, -1, 4'd0);
        check("sat_pos_L", 64'(output_data[0]), 64'h7FFFFF);
        check("sat_pos_R", 64'(output_data[1]), 64'h7FFFFF);
        repeat (45) do_packet(24'h800000, 24'h800000, 4'd3, -1, -1, 4'd0);
        check("sat_neg_L", 64'(output_data[0]), 64'h800000);
        check("sat_neg_R", 64'(output_data[1]), 64'h800000);

        // Reset at MAC cycle 40.
        @(negedge clk);
        new_packet = 1'b1;
        input_data[0] = 24'h123456;
        input_data[1] = 24'h654321;
        sw = 4'd4;
        @(negedge clk);
        new_packet = 1'b0;
        repeat (41) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_out", 64'(output_data), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_overrun", 64'(overrun), 64'd0);
        check("mid_rst_sel", 64'(selected_filter), 64'd0);
        check("mid_rst_addr", 64'(coef_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        hist_l.delete();
        hist_r.delete();
        nvalid = 0;
        repeat (120) begin
            @(negedge clk);
            if (out_valid === 1'b1) nvalid++;
        end
        check("no_partial_valid", 64'(nvalid), 64'd0);
        do_packet(24'h100000, 24'hF0000F, 4'd0, -1, -1, 4'd0);
        check("imp2_L", 64'(output_data[0]), 64'h080000);
        check("imp2_R", 64'(output_data[1]), 64'hF80008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
